y_issue: RTL and testbench

- Decode-and-issue stage directly upstream of the 32-bit ALU.
- Accepts one MIPS-style instruction word per handshake and reads rs/rt from an internal 32x32 register file.
- Selects the ALU operands and the 3-bit ALU op, then holds them in a registered valid/ready output buffer that drives the ALU's a, b and op inputs.
- A per-register busy scoreboard stalls any instruction whose source register still has an uncommitted write.

---
 rtl/y_issue.sv | 191 +++++++++++++++++++
 tb/tb_y_issue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/y_issue.sv
// Decode-and-issue stage feeding the 32-bit ALU: register file, busy scoreboard,
// operand/op selection and a registered valid/ready output buffer.
module y_issue #(
  parameter int W    = 32,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  ins,
  input  logic         wb_en,
  input  logic [4:0]   wb_reg,
  input  logic [W-1:0] wb_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic [4:0]   dest,
  output logic         illegal
);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [W-1:0]    regs [NREG];
  logic [NREG-1:0] busy;

  logic [5:0]  op_f;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op_f  = ins[31:26];
  assign rs    = ins[25:21];
  assign rt    = ins[20:16];
  assign rd    = ins[15:11];
  assign funct = ins[5:0];
  assign imm   = ins[15:0];

  logic         rtype;
  logic         dec_legal;
  alu_op_e      dec_op;
  logic [4:0]   dec_dest;
  logic [W-1:0] dec_b;
  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b;
  logic [W-1:0] imm_sext;
  logic [W-1:0] imm_zext;

  assign rtype    = (op_f == OP_RTYPE);
  assign imm_sext = {{(W-16){imm[15]}}, imm};
  assign imm_zext = {{(W-16){1'b0}}, imm};

  // Read ports with same-cycle write-back bypass; index 0 always reads zero.
  always_comb begin
    rd_a = regs[rs];
    if (rs == 5'd0)                      rd_a = '0;
    else if (wb_en && (wb_reg == rs))    rd_a = wb_data;

    rd_b = regs[rt];
    if (rt == 5'd0)                      rd_b = '0;
    else if (wb_en && (wb_reg == rt))    rd_b = wb_data;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_AND;
    dec_dest  = rt;
    dec_b     = rd_b;
    case (op_f)
      OP_RTYPE: begin
        dec_dest  = rd;
        dec_legal = 1'b1;
        case (funct)
          FN_AND:  dec_op = ALU_AND;
          FN_OR:   dec_op = ALU_OR;
          FN_ADD:  dec_op = ALU_ADD;
          FN_SUB:  dec_op = ALU_SUB;
          FN_SLT:  dec_op = ALU_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec_legal = 1'b1;
        dec_op    = ALU_ADD;
        dec_b     = imm_sext;
      end
      OP_SLTI: begin
        dec_legal = 1'b1;
        dec_op    = ALU_SLT;
        dec_b     = imm_sext;
      end
      OP_ANDI: begin
        dec_legal = 1'b1;
        dec_op    = ALU_AND;
        dec_b     = imm_zext;
      end
      OP_ORI: begin
        dec_legal = 1'b1;
        dec_op    = ALU_OR;
        dec_b     = imm_zext;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // A source is ready if it is not busy, or its write-back is arriving this cycle.
  logic rs_busy;
  logic rt_busy;
  logic src_busy;
  logic accept;
  logic load;

  assign rs_busy  = (rs != 5'd0) && busy[rs] && !(wb_en && (wb_reg == rs));
  assign rt_busy  = (rt != 5'd0) && busy[rt] && !(wb_en && (wb_reg == rt));
  assign src_busy = rs_busy || (rtype && rt_busy);
  assign in_ready = (!out_valid || out_ready) && !src_busy;
  assign accept   = in_valid && in_ready;
  assign load     = accept && dec_legal;

  // Clear on write-back first, then set on issue, so a same-cycle set wins.
  logic [NREG-1:0] busy_next;
  always_comb begin
    busy_next = busy;
    if (wb_en) busy_next[wb_reg] = 1'b0;
    if (load && (dec_dest != 5'd0)) busy_next[dec_dest] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: the register file is reset explicitly because reset must clear every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && (wb_reg != 5'd0)) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'b000;
      dest      <= 5'd0;
    end else if (load) begin
      out_valid <= 1'b1;
      alu_a     <= rd_a;
      alu_b     <= dec_b;
      alu_op    <= dec_op;
      dest      <= dec_dest;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky until reset; an illegal word is consumed but never reaches the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    illegal <= 1'b0;
    else if (accept && !dec_legal) illegal <= 1'b1;
  end

endmodule

// File: tb/tb_y_issue.sv
// Self-checking bench for y_issue: directed vectors, literal expectations and a
// behavioural model compared against the outputs every cycle.
module tb_y_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ins;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  dest;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  y_issue #(.W(32), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .ins(ins),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .dest(dest),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_reg [32];
  logic        m_busy [32];
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_dest;
  logic        m_ill;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_op = 3'd0; m_dest = 5'd0; m_ill = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_en && wb_reg == r) return wb_data;
    return m_reg[r];
  endfunction

  function automatic logic m_pending(input logic [4:0] r);
    return (r != 0) && m_busy[r] && !(wb_en && wb_reg == r);
  endfunction

  function automatic logic m_ready();
    logic hazard;
    hazard = m_pending(ins[25:21]) || (ins[31:26] == 6'h00 && m_pending(ins[20:16]));
    return (!m_valid || out_ready) && !hazard;
  endfunction

  // Meaning of an instruction: legal flag, op code, b operand and destination.
  task automatic m_decode(output logic ok, output logic [2:0] op,
                          output logic [31:0] b, output logic [4:0] d);
    logic [31:0] se, ze;
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    ok = 1'b1; op = 3'd0; b = 32'd0; d = ins[20:16];
    if (ins[31:26] == 6'h00) begin
      d = ins[15:11];
      b = m_read(ins[20:16]);
      if      (ins[5:0] == 6'h24) op = 3'b000;
      else if (ins[5:0] == 6'h25) op = 3'b001;
      else if (ins[5:0] == 6'h20) op = 3'b010;
      else if (ins[5:0] == 6'h22) op = 3'b110;
      else if (ins[5:0] == 6'h2A) op = 3'b111;
      else ok = 1'b0;
    end
    else if (ins[31:26] == 6'h08) begin op = 3'b010; b = se; end
    else if (ins[31:26] == 6'h0A) begin op = 3'b111; b = se; end
    else if (ins[31:26] == 6'h0C) begin op = 3'b000; b = ze; end
    else if (ins[31:26] == 6'h0D) begin op = 3'b001; b = ze; end
    else ok = 1'b0;
  endtask

  task automatic model_step();
    logic ok, acc;
    logic [2:0] op;
    logic [31:0] a, b;
    logic [4:0] d;
    m_decode(ok, op, b, d);
    a   = m_read(ins[25:21]);
    acc = in_valid && m_ready();
    if (wb_en) m_busy[wb_reg] = 1'b0;
    if (acc && ok) begin
      m_valid = 1'b1; m_a = a; m_b = b; m_op = op; m_dest = d;
      if (d != 0) m_busy[d] = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (acc && !ok) m_ill = 1'b1;
    if (wb_en && wb_reg != 0) m_reg[wb_reg] = wb_data;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else       model_step();
    end
  end

  // Compare process: mid-cycle, inputs and outputs are settled.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("m_in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
        check("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("m_illegal", {31'd0, illegal}, {31'd0, m_ill});
        if (m_valid) begin
          check("m_alu_a", alu_a, m_a);
          check("m_alu_b", alu_b, m_b);
          check("m_alu_op", {29'd0, alu_op}, {29'd0, m_op});
          check("m_dest", {27'd0, dest}, {27'd0, m_dest});
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [4:0] d);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_a"}, alu_a, a);
    check({tag, "_b"}, alu_b, b);
    check({tag, "_op"}, {29'd0, alu_op}, {29'd0, op});
    check({tag, "_dest"}, {27'd0, dest}, {27'd0, d});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ins = 32'd0; wb_en = 1'b0; wb_reg = 5'd0;
    wb_data = 32'd0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check("rst_dest", {27'd0, dest}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    cyc(); cyc();
    reset = 1'b0;

    // R1=5, R2=7
    wb_en = 1'b1; wb_reg = 5'd1; wb_data = 32'd5; cyc();
    wb_reg = 5'd2; wb_data = 32'd7; cyc();
    wb_en = 1'b0;

    // add r3, r1, r2
    in_valid = 1'b1; ins = 32'h00221820; #1;
    check("add_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    expect_out("add", 32'd5, 32'd7, 3'b010, 5'd3);
    check("add_busy3", {31'd0, dut.busy[3]}, 32'd1);

    // addi then ori back-to-back
    ins = 32'h2024FFFF; cyc();
    expect_out("addi", 32'd5, 32'hFFFFFFFF, 3'b010, 5'd4);
    ins = 32'h3424FFFF; cyc();
    expect_out("ori", 32'd5, 32'h0000FFFF, 3'b001, 5'd4);

    // sub r5, r3, r2 stalls on busy r3
    ins = 32'h00622822;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sub_stall", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'd12; #1;
    check("sub_bypass_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    wb_en = 1'b0;
    expect_out("sub", 32'd12, 32'd7, 3'b110, 5'd5);

    // back-pressure with add r6, r1, r2 waiting
    out_ready = 1'b0; ins = 32'h00223020;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      cyc();
      expect_out("bp_hold", 32'd12, 32'd7, 3'b110, 5'd5);
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    expect_out("add6", 32'd5, 32'd7, 3'b010, 5'd6);

    // illegal opcode 0x3F
    ins = 32'hFC000000; cyc();
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_no_valid", {31'd0, out_valid}, 32'd0);

    // and r0, r1, r2 : no destination, no busy
    ins = 32'h00220024; cyc();
    expect_out("and_r0", 32'd5, 32'd7, 3'b000, 5'd0);
    check("busy0", {31'd0, dut.busy[0]}, 32'd0);
    in_valid = 1'b0; wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'd99; cyc();
    wb_en = 1'b0;
    in_valid = 1'b1; ins = 32'h00003825; #1;
    check("or_r0_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    expect_out("or_r0", 32'd0, 32'd0, 3'b001, 5'd7);
    check("ill_sticky", {31'd0, illegal}, 32'd1);

    // add r5 then hold and reset asynchronously
    ins = 32'h00222820; cyc();
    in_valid = 1'b0; out_ready = 1'b0; cyc();
    expect_out("pre_rst", 32'd5, 32'd7, 3'b010, 5'd5);
    check("pre_rst_busy5", {31'd0, dut.busy[5]}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy", dut.busy, 32'd0);
    check("arst_r1", dut.regs[1], 32'd0);
    check("arst_r2", dut.regs[2], 32'd0);
    check("arst_illegal", {31'd0, illegal}, 32'd0);
    cyc();
    reset = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; ins = 32'h00221820; cyc();
    in_valid = 1'b0;
    expect_out("post_rst", 32'd0, 32'd0, 3'b010, 5'd3);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
